msrv32_reg_file_mp: RTL and testbench
=====================================

# msrv32_reg_file_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It replaces the single-write, two-read register file in the decode/writeback stage of the msrv32 core. It adds configurable read and write port counts, per-port read enables with output hold, deterministic write-to-read bypass, and scoreboard tracking for in-flight destination registers so the issue logic can detect RAW hazards.

## Interface
- WIDTH, 32, data width per register
- DEPTH, 32, number of registers; register 0 is hardwired to zero
- ADDR_WIDTH, 5, address width, equal to $clog2(DEPTH)
- RD_PORTS, 2, number of read ports (1..4)
- WR_PORTS, 1, number of write ports (1..2)

Ports:
- msrv32_mp_clk_in  in  1  clock; all state updates on the rising edge
- msrv32_mp_rst_n_in  in  1  asynchronous, active-low reset
- rd_en_in  in  RD_PORTS  per-port read enable
- rs_addr_in  in  RD_PORTS*ADDR_WIDTH  read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- rs_out  out  RD_PORTS*WIDTH  registered read data, sliced as above
- rs_busy_out  out  RD_PORTS  registered busy flag of the register read on each port
- wr_en_in  in  WR_PORTS  per-port write enable
- wr_addr_in  in  WR_PORTS*ADDR_WIDTH  write addresses
- wr_data_in  in  WR_PORTS*WIDTH  write data
- issue_en_in  in  1  marks issue_addr_in as having an in-flight producer
- issue_addr_in  in  ADDR_WIDTH  destination register of the issued instruction
- busy_vec_out  out  DEPTH  current scoreboard; bit 0 is always 0

## Operation
- Reset asserted (asynchronously): all registers, rs_out, rs_busy_out and busy_vec_out are cleared to 0. Reset deassertion takes effect at the next edge.
- Write: on an edge with wr_en_in[w]=1 and wr_addr≠0, register[wr_addr] takes wr_data. Writes to address 0 are discarded.
- Write collision: if both write ports target the same address, port WR_PORTS-1 (the highest index) wins.
- Read: on an edge with rd_en_in[p]=1, rs_out[p] loads the read value:
  - address 0 gives 0;
  - otherwise, if any enabled write port targets the same address in this cycle, the winning write data is used (bypass);
  - otherwise the stored value is used.
- With rd_en_in[p]=0, rs_out[p] and rs_busy_out[p] hold their values.
- Scoreboard:
  - An enabled write clears busy[wr_addr].
  - issue_en_in sets busy[issue_addr]. Issue wins over a same-cycle write clear, because a new producer supersedes the old one.
  - Address 0 is never set.
- rs_busy_out[p] loads the post-update busy value of the addressed register, on the same edge as rs_out[p].
- Duplicate read addresses across ports are legal and return identical data.

## Timing
- Read latency is 1 cycle: the address presented before edge N produces data valid after edge N.
- The write becomes visible to a same-cycle read via the bypass, with no stall cycle.
- The scoreboard updates on the same edge as the write. busy_vec_out is a direct register output with no combinational path from the inputs.
- Reset asserted mid-operation wins over every in-flight write, issue and read.

## Structure
- Shared package msrv32_pkg holds:
  - WIDTH, DEPTH and ADDR_WIDTH defaults;
  - the X0 address constant;
  - typedefs for the register word and the register address.
- One sub-module, msrv32_rf_bypass_sel, is instantiated per read port. It is combinational and takes the read address, the write enables, addresses and data, and the stored value. It outputs the selected next value, applying the x0 and highest-port-wins rules.
- The storage array, scoreboard and output registers live in the top module.

## Test plan
- Reset:
  - Drive random writes, then pulse msrv32_mp_rst_n_in low for half a cycle between edges.
  - Required: rs_out, rs_busy_out and busy_vec_out go to 0 immediately.
  - Required: reading registers 1..31 afterwards returns 0.
- Write/read:
  - Write 0xDEADBEEF to x5 on port 0, then read x5 on both read ports the next cycle.
  - Required: both rs_out slices equal 0xDEADBEEF after one edge.
- Bypass and collision (WR_PORTS=2):
  - In one cycle, write port 0 writes x7=0x11 and port 1 writes x7=0x22, while a read of x7 is enabled.
  - Required: rs_out = 0x22 after the edge, and x7 still reads 0x22 later.
- x0:
  - Write 0xFFFFFFFF to x0 with a same-cycle read and an issue to x0.
  - Required: rs_out = 0, and busy_vec_out[0] = 0.
- Scoreboard:
  - Issue x9; busy_vec_out[9]=1 after one edge.
  - Write x9 while issuing x9 in the same cycle; busy stays 1.
  - Write x9 alone; busy goes to 0.
  - A read of x9 in each of these cycles reports the matching rs_busy_out.
- Hold:
  - Read x3=0x55, then drop rd_en_in and write x3=0x66.
  - Required: rs_out holds 0x55 until rd_en_in rises again, then shows 0x66.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 register file slice.
package msrv32_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_DEPTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_WIDTH-1:0]      word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

  // x0 is hardwired to zero and never marked busy.
  localparam addr_t X0_ADDR = '0;

endpackage

// File: rtl/msrv32_rf_bypass_sel.sv
// Per-read-port next-value select: x0 forces zero, otherwise the highest-index
// write port hitting the read address wins over the stored value.
module msrv32_rf_bypass_sel
  import msrv32_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned WR_PORTS   = 1
) (
  input  logic [ADDR_WIDTH-1:0]          rs_addr_i,
  input  logic [WR_PORTS-1:0]            wr_en_i,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WR_PORTS*WIDTH-1:0]      wr_data_i,
  input  logic [WIDTH-1:0]               stored_i,
  output logic [WIDTH-1:0]               next_val_o
);

  // Ascending scan so the last matching (highest) write port overrides.
  always_comb begin
    next_val_o = stored_i;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == rs_addr_i)) begin
        next_val_o = wr_data_i[w*WIDTH +: WIDTH];
      end
    end
    if (rs_addr_i == ADDR_WIDTH'(X0_ADDR)) begin
      next_val_o = '0;
    end
  end

endmodule

// File: rtl/msrv32_reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy
// scoreboard for in-flight destination registers.
module msrv32_reg_file_mp
  import msrv32_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned WR_PORTS   = 1
) (
  input  logic                           msrv32_mp_clk_in,
  input  logic                           msrv32_mp_rst_n_in,
  input  logic [RD_PORTS-1:0]            rd_en_in,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rs_addr_in,
  output logic [RD_PORTS*WIDTH-1:0]      rs_out,
  output logic [RD_PORTS-1:0]            rs_busy_out,
  input  logic [WR_PORTS-1:0]            wr_en_in,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [WR_PORTS*WIDTH-1:0]      wr_data_in,
  input  logic                           issue_en_in,
  input  logic [ADDR_WIDTH-1:0]          issue_addr_in,
  output logic [DEPTH-1:0]               busy_vec_out
);

  logic [WIDTH-1:0]          regs_q [DEPTH];
  logic [WIDTH-1:0]          regs_d [DEPTH];
  logic [DEPTH-1:0]          busy_q, busy_d;
  logic [RD_PORTS*WIDTH-1:0] rs_q, rs_d;
  logic [RD_PORTS-1:0]       rs_busy_q, rs_busy_d;
  logic [WIDTH-1:0]          stored [RD_PORTS];
  logic [WIDTH-1:0]          sel_val [RD_PORTS];

  // Storage next state: ascending port order gives highest-port-wins on collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_in[w] &&
          (wr_addr_in[w*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(X0_ADDR))) begin
        regs_d[wr_addr_in[w*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data_in[w*WIDTH +: WIDTH];
      end
    end
  end

  // Scoreboard next state: writes clear, then a new issue re-sets (issue wins).
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_in[w]) begin
        busy_d[wr_addr_in[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (issue_en_in) begin
      busy_d[issue_addr_in] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
    assign stored[p] = regs_q[rs_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]];

    msrv32_rf_bypass_sel #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .WR_PORTS   (WR_PORTS)
    ) u_bypass_sel (
      .rs_addr_i  (rs_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_en_i    (wr_en_in),
      .wr_addr_i  (wr_addr_in),
      .wr_data_i  (wr_data_in),
      .stored_i   (stored[p]),
      .next_val_o (sel_val[p])
    );
  end

  // Read outputs load on enable and hold otherwise; busy reflects the post-update scoreboard.
  always_comb begin
    rs_d      = rs_q;
    rs_busy_d = rs_busy_q;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rd_en_in[p]) begin
        rs_d[p*WIDTH +: WIDTH] = sel_val[p];
        rs_busy_d[p]           = busy_d[rs_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      rs_q      <= '0;
      rs_busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q    <= busy_d;
      rs_q      <= rs_d;
      rs_busy_q <= rs_busy_d;
    end
  end

  assign rs_out       = rs_q;
  assign rs_busy_out  = rs_busy_q;
  assign busy_vec_out = busy_q;

endmodule

// File: tb/tb_msrv32_reg_file_mp.sv
// Directed bench for msrv32_reg_file_mp with two read and two write ports.
module tb_msrv32_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rs_addr;
  logic [63:0] rs_out;
  logic [1:0]  rs_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [31:0] busy_vec;

  int tests = 0;
  int fails = 0;
  logic [31:0] rnd;

  msrv32_reg_file_mp #(
    .WIDTH      (32),
    .DEPTH      (32),
    .ADDR_WIDTH (5),
    .RD_PORTS   (2),
    .WR_PORTS   (2)
  ) dut (
    .msrv32_mp_clk_in   (clk),
    .msrv32_mp_rst_n_in (rst_n),
    .rd_en_in           (rd_en),
    .rs_addr_in         (rs_addr),
    .rs_out             (rs_out),
    .rs_busy_out        (rs_busy),
    .wr_en_in           (wr_en),
    .wr_addr_in         (wr_addr),
    .wr_data_in         (wr_data),
    .issue_en_in        (issue_en),
    .issue_addr_in      (issue_addr),
    .busy_vec_out       (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en    = 2'b00;
    wr_en    = 2'b00;
    issue_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_en      = '0;
    rs_addr    = '0;
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    step();
    step();
    check("reset_rs", rs_out[31:0] | rs_out[63:32], 32'h0);
    check("reset_busy", 32'(rs_busy), 32'h0);
    check("reset_vec", busy_vec, 32'h0);
    rst_n = 1'b1;

    // Write x5 on port 0, then read it on both ports.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    step();
    idle();
    rd_en = 2'b11; rs_addr = {5'd5, 5'd5};
    step();
    check("wr_rd_p0", rs_out[31:0], 32'hDEADBEEF);
    check("wr_rd_p1", rs_out[63:32], 32'hDEADBEEF);
    check("wr_rd_busy", 32'(rs_busy), 32'h0);

    // Both write ports hit x7 while port 0 reads it: port 1 data bypasses.
    idle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_en = 2'b01; rs_addr = {5'd5, 5'd7};
    step();
    check("collide_bypass", rs_out[31:0], 32'h22);
    check("collide_p1_hold", rs_out[63:32], 32'hDEADBEEF);
    idle();
    rd_en = 2'b10; rs_addr = {5'd7, 5'd0};
    step();
    check("collide_stored", rs_out[63:32], 32'h22);
    check("collide_p0_hold", rs_out[31:0], 32'h22);

    // x0 write, read and issue together.
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
    rd_en = 2'b01; rs_addr = {5'd0, 5'd0};
    issue_en = 1'b1; issue_addr = 5'd0;
    step();
    check("x0_read", rs_out[31:0], 32'h0);
    check("x0_busy", 32'(busy_vec[0]), 32'h0);
    check("x0_vec", busy_vec, 32'h0);

    // Scoreboard: issue, issue+write, write alone.
    idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    rd_en = 2'b01; rs_addr = {5'd0, 5'd9};
    step();
    check("sb_issue_vec", busy_vec, 32'h0000_0200);
    check("sb_issue_rs", 32'(rs_busy[0]), 32'h1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
    step();
    check("sb_both_vec", 32'(busy_vec[9]), 32'h1);
    check("sb_both_rs", 32'(rs_busy[0]), 32'h1);
    check("sb_both_data", rs_out[31:0], 32'h99);
    issue_en = 1'b0;
    wr_data = {32'h0, 32'hA9};
    step();
    check("sb_wr_vec", busy_vec, 32'h0);
    check("sb_wr_rs", 32'(rs_busy[0]), 32'h0);
    check("sb_wr_data", rs_out[31:0], 32'hA9);

    // Hold: output keeps old value while read enable is low.
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h55};
    step();
    idle();
    rd_en = 2'b01; rs_addr = {5'd0, 5'd3};
    step();
    check("hold_first", rs_out[31:0], 32'h55);
    idle();
    wr_en = 2'b01; wr_data = {32'h0, 32'h66};
    issue_en = 1'b1; issue_addr = 5'd3;
    step();
    check("hold_wr", rs_out[31:0], 32'h55);
    check("hold_busy", 32'(rs_busy[0]), 32'h0);
    idle();
    step();
    check("hold_idle", rs_out[31:0], 32'h55);
    rd_en = 2'b01;
    step();
    check("hold_release", rs_out[31:0], 32'h66);
    check("hold_release_busy", 32'(rs_busy[0]), 32'h1);

    // Random writes, then a mid-cycle reset pulse.
    idle();
    for (int i = 1; i < 32; i += 4) begin
      rnd = $urandom() | 32'h1;
      wr_en = 2'b01; wr_addr = {5'd0, 5'(i)}; wr_data = {32'h0, rnd};
      issue_en = 1'b1; issue_addr = 5'(i + 1);
      step();
    end
    idle();
    rd_en = 2'b11; rs_addr = {5'd2, 5'(29)};
    step();
    check("pre_reset_data", rs_out[31:0], rnd);
    check("pre_reset_busy", 32'(rs_busy[1]), 32'h1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rs", rs_out[31:0] | rs_out[63:32], 32'h0);
    check("async_busy", 32'(rs_busy), 32'h0);
    check("async_vec", busy_vec, 32'h0);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rd_en = 2'b11; rs_addr = {5'(i), 5'(i)};
      step();
      check($sformatf("post_reset_x%0d", i), rs_out[31:0] | rs_out[63:32], 32'h0);
    end
    check("post_reset_vec", busy_vec, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
